mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, 32, address width of all ports.
REQ-002 SHALL have parameter DW, 32, data width of all ports.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports if_req input 1, if_addr input AW, if_rdata output DW, if_ack output 1, forming the fetch-stage read channel.
REQ-006 SHALL have ports ls_req input 1, ls_we input 1, ls_addr input AW, ls_wdata input DW, ls_bmask input 4, ls_rdata output DW, ls_ack output 1, forming the MEM-stage load/store channel.
REQ-007 SHALL have ports mem_req output 1, mem_we output 1, mem_addr output AW, mem_wdata output DW, mem_bmask output 4, mem_rdata input DW, mem_ack input 1, forming the single shared memory port.
REQ-008 SHALL have ports stall_if output 1 and stall_ls output 1, feeding the pipeline stall/flush logic.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY_IF, BUSY_LS.
REQ-010 In IDLE with any request, SHALL grant one requester, register its address/we/wdata/bmask into mem_* and enter BUSY_IF or BUSY_LS on the same edge.
REQ-011 With only one requester active, SHALL grant that requester.
REQ-012 With both active and ARB_RR_EN undefined, SHALL grant LS (fixed priority).
REQ-013 IF grants SHALL drive mem_we=0 and mem_bmask=4'b1111.
REQ-014 In BUSY_x, mem_req SHALL be 1 and mem_* SHALL stay constant until mem_ack=1.
REQ-015 On the mem_ack cycle, SHALL assert x_ack=1 for exactly that cycle, drive x_rdata=mem_rdata combinationally and return to IDLE on the next edge.
REQ-016 Minimum request-to-ack latency SHALL be 1 cycle: request sampled at edge N, mem_req high in cycle N+1, ack in cycle N+1 if memory acks that cycle.
REQ-017 No new grant SHALL occur in the cycle of mem_ack; back-to-back transactions therefore have one IDLE cycle between them.
REQ-018 x_rdata SHALL be 0 whenever x_ack=0.
REQ-019 stall_if SHALL equal if_req & ~if_ack; stall_ls SHALL equal ls_req & ~ls_ack (combinational).
REQ-020 If a requester drops req mid-transaction, the transaction SHALL still complete and x_ack SHALL still pulse.
REQ-021 mem_ack while in IDLE SHALL be ignored; no ack output is generated.

Reset
REQ-022 While rst=1, SHALL be in IDLE with mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_bmask=0, if_ack=0, ls_ack=0, round-robin pointer=LS-last, asynchronously.
REQ-023 Reset asserted mid-transaction SHALL abort it with no ack pulse; the first grant after release follows REQ-010.

Configuration
REQ-024 With macro ARB_RR_EN defined, simultaneous requests SHALL be granted to the requester not granted last (1-bit pointer updated at each grant); the first contested grant after reset goes to IF.
REQ-025 With ARB_RR_EN undefined, the pointer SHALL not exist and REQ-012 applies.

Verification
REQ-026 Scenario: only if_req=1, if_addr=0x100, memory acks 1 cycle after mem_req -> mem_addr=0x100, mem_we=0, if_ack pulses once, if_rdata=mem_rdata.
REQ-027 Scenario: if_req=ls_req=1 together, ls_we=1, ls_addr=0x2000, ls_wdata=0xDEADBEEF, ls_bmask=0x3, macro off -> LS served first with mem_wdata=0xDEADBEEF, mem_bmask=0x3; IF served after one IDLE cycle; stall_if=1 throughout.
REQ-028 Scenario: same as REQ-027 with ARB_RR_EN defined, both requests held for 4 transactions -> grant order IF, LS, IF, LS.
REQ-029 Scenario: memory holds mem_ack=0 for 5 cycles -> mem_req and mem_addr stable for all 5 cycles; stall_ls=1 until the ack cycle.
REQ-030 Scenario: rst=1 during BUSY_LS before mem_ack -> mem_req=0 immediately, no ls_ack; after release with ls_req=1, a fresh grant occurs.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client arbiter for a single shared memory port.
//
// Clients: the fetch stage (IF, read-only) and the MEM stage (LS, load/store).
// One transaction is outstanding at a time. A grant registers the winner's
// address/we/wdata/bmask onto mem_*, and they stay constant until mem_ack.
// The client ack and read data are combinational from mem_ack/mem_rdata.
// After each ack there is one IDLE cycle before the next grant.
//
// Optional feature macro: ARB_RR_EN
//   undefined : simultaneous requests go to LS (fixed priority)
//   defined   : simultaneous requests go to the client not granted last;
//               the first contested grant after reset goes to IF
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_req/if_addr           fetch read request
//   if_rdata/if_ack          fetch read data and one-cycle ack
//   ls_req/ls_we/ls_addr     load/store request
//   ls_wdata/ls_bmask        store data and byte mask
//   ls_rdata/ls_ack          load data and one-cycle ack
//   mem_*                    shared memory port
//   stall_if/stall_ls        request pending and not acked this cycle
//
// State table:
//   state   | meaning
//   IDLE    | no transaction outstanding; grants happen here
//   BUSY_IF | fetch transaction on mem_*, waiting for mem_ack
//   BUSY_LS | load/store transaction on mem_*, waiting for mem_ack

module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    input  logic [3:0]    ls_bmask,
    output logic [DW-1:0] ls_rdata,
    output logic          ls_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_bmask,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall_if,
    output logic          stall_ls
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   grant_if, grant_ls;

`ifdef ARB_RR_EN
    // 1 when LS was the last client granted; reset makes IF win first.
    logic last_ls;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_ls  = 1'b0;
        if_ack    = 1'b0;
        ls_ack    = 1'b0;
        mem_req   = 1'b0;
        case (state)
            IDLE: begin
                // mem_ack is ignored here: nothing is outstanding.
                if (if_req && ls_req) begin
`ifdef ARB_RR_EN
                    if (last_ls) grant_if = 1'b1;
                    else         grant_ls = 1'b1;
`else
                    grant_ls = 1'b1;
`endif
                end else if (if_req) begin
                    grant_if = 1'b1;
                end else if (ls_req) begin
                    grant_ls = 1'b1;
                end
                if (grant_if)      state_nxt = BUSY_IF;
                else if (grant_ls) state_nxt = BUSY_LS;
            end
            BUSY_IF: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    if_ack    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            BUSY_LS: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ls_ack    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are captured only at grant so they hold steady while
    // the client is free to change or drop its own request lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_bmask <= 4'b0000;
        end else if (grant_if) begin
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_bmask <= 4'b1111;
        end else if (grant_ls) begin
            mem_we    <= ls_we;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
            mem_bmask <= ls_bmask;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           last_ls <= 1'b1;
        else if (grant_ls) last_ls <= 1'b1;
        else if (grant_if) last_ls <= 1'b0;
    end
`endif

    assign if_rdata = if_ack ? mem_rdata : '0;
    assign ls_rdata = ls_ack ? mem_rdata : '0;
    assign stall_if = if_req & ~if_ack;
    assign stall_ls = ls_req & ~ls_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req, ls_req, ls_we, mem_ack;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic [3:0]  ls_bmask;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
    logic        if_ack, ls_ack, mem_req, mem_we, stall_if, stall_ls;
    logic [3:0]  mem_bmask;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_bmask(ls_bmask), .ls_rdata(ls_rdata), .ls_ack(ls_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_bmask(mem_bmask), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .stall_if(stall_if), .stall_ls(stall_ls)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: which client owns the port (0 none, 1 IF, 2 LS),
    // the transaction it was granted, and who won the last grant.
    int          owner;
    logic        m_we, m_last_ls;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_bmask;
    logic        prev_mem_req;
    int          obs_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        owner     = 0;
        m_we      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        m_bmask   = 4'b0000;
        m_last_ls = 1'b1;
    endtask

    task automatic check_outputs();
        logic e_if_ack, e_ls_ack;
        e_if_ack = (owner == 1) && mem_ack;
        e_ls_ack = (owner == 2) && mem_ack;
        chk("mem_req",   mem_req,   owner != 0);
        chk("mem_addr",  mem_addr,  m_addr);
        chk("mem_we",    mem_we,    m_we);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("mem_bmask", mem_bmask, m_bmask);
        chk("if_ack",    if_ack,    e_if_ack);
        chk("ls_ack",    ls_ack,    e_ls_ack);
        chk("if_rdata",  if_rdata,  e_if_ack ? mem_rdata : 32'h0);
        chk("ls_rdata",  ls_rdata,  e_ls_ack ? mem_rdata : 32'h0);
        chk("stall_if",  stall_if,  if_req && !e_if_ack);
        chk("stall_ls",  stall_ls,  ls_req && !e_ls_ack);
        // Grants are separated by an idle cycle, so each rising mem_req is a new grant.
        if (mem_req && !prev_mem_req) obs_log.push_back((mem_addr == 32'h2000) ? 2 : 1);
        prev_mem_req = mem_req;
    endtask

    task automatic model_edge();
        int pick;
        if (rst) begin
            model_reset();
        end else if (owner == 0) begin
            if (if_req || ls_req) begin
                if (if_req && ls_req) begin
`ifdef ARB_RR_EN
                    pick = m_last_ls ? 1 : 2;
`else
                    pick = 2;
`endif
                end else begin
                    pick = if_req ? 1 : 2;
                end
                owner     = pick;
                m_last_ls = (pick == 2);
                if (pick == 1) begin
                    m_we = 1'b0; m_addr = if_addr; m_wdata = '0; m_bmask = 4'hF;
                end else begin
                    m_we = ls_we; m_addr = ls_addr; m_wdata = ls_wdata; m_bmask = ls_bmask;
                end
            end
        end else if (mem_ack) begin
            owner = 0;
        end
    endtask

    // Inputs are set right after a falling edge; outputs are checked 1ns later,
    // then the model follows the rising edge.
    task automatic tick();
        #1 check_outputs();
        @(posedge clk);
        #0 model_edge();
        @(negedge clk);
    endtask

    initial begin
        int n_want;
        int exp_order[4];
        logic was_ls;

        if_req = 0; ls_req = 0; ls_we = 0; mem_ack = 0;
        if_addr = 0; ls_addr = 0; ls_wdata = 0; ls_bmask = 0; mem_rdata = 0;
        prev_mem_req = 1'b0;
        model_reset();

        // Reset: everything idle and cleared, requests and mem_ack ignored.
        #2 rst = 1'b1;
        tick();
        if_req = 1; ls_req = 1; mem_ack = 1; mem_rdata = 32'h12345678;
        tick();
        if_req = 0; ls_req = 0; mem_ack = 0;
        rst = 1'b0;
        tick();

        // Contested requests: LS then IF (fixed), or IF,LS,IF,LS (round robin).
        obs_log.delete();
        if_req = 1; if_addr = 32'h100;
        ls_req = 1; ls_we = 1; ls_addr = 32'h2000; ls_wdata = 32'hDEADBEEF; ls_bmask = 4'h3;
`ifdef ARB_RR_EN
        n_want = 4; exp_order = '{1, 2, 1, 2};
`else
        n_want = 2; exp_order = '{2, 1, 0, 0};
`endif
        for (int c = 0; c < 40 && obs_log.size() < n_want; c++) begin
            mem_ack   = (owner != 0);
            mem_rdata = $urandom;
            was_ls    = (owner == 2) && mem_ack;
            tick();
`ifndef ARB_RR_EN
            if (was_ls) ls_req = 0;
`endif
        end
        if_req = 0; ls_req = 0; mem_ack = 0;
        tick();
        chk("contest_count", obs_log.size(), n_want);
        for (int i = 0; i < n_want && i < obs_log.size(); i++)
            chk($sformatf("contest_grant%0d", i), obs_log[i], exp_order[i]);

        // Single fetch, memory acks on the second busy cycle.
        if_req = 1; if_addr = 32'h100;
        tick();
        if_req = 0;
        tick();
        chk("fetch_addr", mem_addr, 32'h100);
        chk("fetch_we", mem_we, 1'b0);
        mem_ack = 1; mem_rdata = 32'hCAFE0001;
        #1 chk("fetch_rdata", if_rdata, 32'hCAFE0001);
        tick();
        mem_ack = 0;
        tick();

        // Load held off for 5 cycles, then acked.
        ls_req = 1; ls_we = 0; ls_addr = 32'h40; ls_bmask = 4'hF; ls_wdata = 32'h0;
        tick();
        ls_addr = 32'h999;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("wait_addr", mem_addr, 32'h40);
            chk("wait_stall_ls", stall_ls, 1'b1);
        end
        mem_ack = 1; mem_rdata = 32'h55AA55AA;
        tick();
        ls_req = 0; mem_ack = 0;
        tick();

        // Reset while a store is outstanding: aborted, no ack, fresh grant later.
        ls_req = 1; ls_we = 1; ls_addr = 32'h2000; ls_wdata = 32'h11112222; ls_bmask = 4'hC;
        tick();
        tick();
        rst = 1'b1; mem_ack = 1;
        model_reset();
        #1 chk("abort_mem_req", mem_req, 1'b0);
        chk("abort_ls_ack", ls_ack, 1'b0);
        tick();
        rst = 1'b0; mem_ack = 0; ls_addr = 32'h3000;
        tick();
        chk("regrant_addr", mem_addr, 32'h3000);
        mem_ack = 1;
        tick();
        ls_req = 0; mem_ack = 0;
        tick();

        // Random traffic: requests held or dropped at will, acks at any time.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) < 3) if_req = $urandom_range(0, 1);
            if ($urandom_range(0, 9) < 3) ls_req = $urandom_range(0, 1);
            if_addr   = $urandom;
            ls_addr   = $urandom;
            ls_we     = $urandom_range(0, 1);
            ls_wdata  = $urandom;
            ls_bmask  = $urandom_range(0, 15);
            mem_ack   = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
